// File: rtl/aes_tlookup_pipe.sv
// Two-stage AES byte substitution and T-table column lookup.
// LANES bytes per beat, valid/ready flow control, sideband tag.
module aes_tlookup_pipe #(
    parameter int LANES  = 4,
    parameter int INV_EN = 1,
    parameter int TAG_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [8*LANES-1:0]  in_data,
    input  logic                in_inv,
    input  logic [TAG_W-1:0]    in_tag,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [8*LANES-1:0]  out_sub,
    output logic [32*LANES-1:0] out_t,
    output logic [TAG_W-1:0]    out_tag
);

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse, and maps 0 to 0 as AES requires
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] r;
        sq = a;
        r  = 8'h01;
        for (int k = 1; k < 8; k++) begin
            sq = gmul(sq, sq);
            r  = gmul(r, sq);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
        logic [15:0] d;
        d = {x, x} << n;
        return d[15:8];
    endfunction

    function automatic logic [7:0] sbox_fwd(input logic [7:0] b);
        logic [7:0] x;
        x = ginv(b);
        return x ^ rotl8(x, 1) ^ rotl8(x, 2) ^ rotl8(x, 3)
                 ^ rotl8(x, 4) ^ 8'h63;
    endfunction

    function automatic logic [7:0] sbox_inv(input logic [7:0] s);
        logic [7:0] y;
        y = rotl8(s, 1) ^ rotl8(s, 3) ^ rotl8(s, 6) ^ 8'h05;
        return ginv(y);
    endfunction

    logic                 adv;
    logic                 inv_in;
    logic [8*LANES-1:0]   sub_d;
    logic [32*LANES-1:0]  t_d;

    logic                 s1_valid;
    logic                 s1_inv;
    logic [8*LANES-1:0]   s1_sub;
    logic [TAG_W-1:0]     s1_tag;

    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;
    assign inv_in   = (INV_EN != 0) && in_inv;

    for (genvar i = 0; i < LANES; i++) begin : g_s1
        logic [7:0] b;
        logic [7:0] s_f;
        logic [7:0] s_i;

        assign b   = in_data[8*(LANES-i)-1 -: 8];
        assign s_f = sbox_fwd(b);

        if (INV_EN != 0) begin : g_inv
            assign s_i = sbox_inv(b);
        end else begin : g_noinv
            assign s_i = 8'h00;
        end

        assign sub_d[8*(LANES-i)-1 -: 8] = inv_in ? s_i : s_f;
    end

    for (genvar i = 0; i < LANES; i++) begin : g_s2
        localparam int R = 8 * (i % 4);
        logic [7:0]  s;
        logic [7:0]  x2;
        logic [31:0] bf;
        logic [31:0] bi;
        logic [31:0] base;

        assign s  = s1_sub[8*(LANES-i)-1 -: 8];
        assign x2 = xtime(s);
        assign bf = {x2, s, s, x2 ^ s};

        if (INV_EN != 0) begin : g_inv
            logic [7:0] x4;
            logic [7:0] x8;
            assign x4 = xtime(x2);
            assign x8 = xtime(x4);
            assign bi = {x8 ^ x4 ^ x2, x8 ^ s, x8 ^ x4 ^ s, x8 ^ x2 ^ s};
        end else begin : g_noinv
            assign bi = 32'h0;
        end

        assign base = s1_inv ? bi : bf;
        // Lanes beyond the fourth reuse the column rotation pattern
        assign t_d[32*(LANES-i)-1 -: 32] =
            (base >> R) | (base << ((32 - R) % 32));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid  <= 1'b0;
            s1_inv    <= 1'b0;
            s1_sub    <= '0;
            s1_tag    <= '0;
            out_valid <= 1'b0;
            out_sub   <= '0;
            out_t     <= '0;
            out_tag   <= '0;
        end else if (adv) begin
            s1_valid  <= in_valid;
            s1_inv    <= inv_in;
            s1_sub    <= sub_d;
            s1_tag    <= in_tag;
            out_valid <= s1_valid;
            out_sub   <= s1_sub;
            out_t     <= t_d;
            out_tag   <= s1_tag;
        end
    end

endmodule

// File: tb/tb_aes_tlookup_pipe.sv
// Scoreboard bench for aes_tlookup_pipe: inverse-enabled and
// forward-only instances driven in lockstep, checked against a GF model.
module tb_aes_tlookup_pipe;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_inv = 1'b0;
    logic         out_ready = 1'b1;
    logic [31:0]  in_data = '0;
    logic [3:0]   in_tag = '0;

    logic         ir1, ov1, ir0, ov0;
    logic [31:0]  os1, os0;
    logic [127:0] ot1, ot0;
    logic [3:0]   og1, og0;

    aes_tlookup_pipe #(.LANES(4), .INV_EN(1), .TAG_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir1),
        .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(ov1), .out_ready(out_ready),
        .out_sub(os1), .out_t(ot1), .out_tag(og1)
    );

    aes_tlookup_pipe #(.LANES(4), .INV_EN(0), .TAG_W(4)) u_fwd (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(ir0),
        .in_data(in_data), .in_inv(in_inv), .in_tag(in_tag),
        .out_valid(ov0), .out_ready(out_ready),
        .out_sub(os0), .out_t(ot0), .out_tag(og0)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0]  sub;
        logic [127:0] t;
        logic [3:0]   tag;
    } exp_t;

    exp_t       q1[$];
    exp_t       q0[$];
    logic [7:0] fwd_tab[256];
    logic [7:0] inv_tab[256];
    int         n_pass = 0;
    int         n_total = 0;
    int         mode = 0;

    localparam logic [127:0] FWD0_T =
        128'hc66363a5_a5c66363_63a5c663_6363a5c6;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Carry-less product followed by reduction modulo x^8+x^4+x^3+x+1
    function automatic logic [7:0] gm(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ ({8'h00, a} << i);
        for (int k = 14; k >= 8; k--)
            if (p[k]) p = p ^ (16'h011b << (k - 8));
        return p[7:0];
    endfunction

    task automatic build_tables();
        logic [7:0] c;
        c = 8'h63;
        for (int x = 0; x < 256; x++) begin
            logic [7:0] v;
            logic [7:0] s;
            v = '0;
            for (int y = 1; y < 256; y++)
                if (gm(8'(x), 8'(y)) == 8'h01) v = 8'(y);
            for (int i = 0; i < 8; i++)
                s[i] = v[i] ^ v[(i+4)%8] ^ v[(i+5)%8] ^ v[(i+6)%8]
                     ^ v[(i+7)%8] ^ c[i];
            fwd_tab[x] = s;
            inv_tab[s] = 8'(x);
        end
    endtask

    function automatic exp_t model(input logic [31:0] d, input logic inv,
                                   input logic [3:0] tag);
        exp_t e;
        logic [31:0] cc;
        cc = inv ? 32'h0e090d0b : 32'h02010103;
        e.tag = tag;
        for (int i = 0; i < 4; i++) begin
            logic [7:0]  b;
            logic [7:0]  s;
            logic [31:0] bw;
            logic [63:0] bb;
            b  = d[8*(4-i)-1 -: 8];
            s  = inv ? inv_tab[b] : fwd_tab[b];
            bw = {gm(s, cc[31:24]), gm(s, cc[23:16]),
                  gm(s, cc[15:8]), gm(s, cc[7:0])};
            bb = {bw, bw};
            e.sub[8*(4-i)-1 -: 8]   = s;
            e.t[32*(4-i)-1 -: 32]   = bb[8*(i%4)+31 -: 32];
        end
        return e;
    endfunction

    task automatic send(input logic [31:0] d, input logic inv,
                        input logic [3:0] tag);
        int w;
        w = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_inv   = inv;
        in_tag   = tag;
        #1;
        while (!ir1) begin
            w++;
            if (w > 1000) begin
                $display("FAIL send_timeout: in_ready low for %0d cycles", w);
                $fatal(1, "stopping");
            end
            @(negedge clk);
            #1;
        end
        q1.push_back(model(d, inv, tag));
        q0.push_back(model(d, 1'b0, tag));
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic directed(input logic [31:0] d, input logic inv);
        send(d, inv, 4'h5);
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("latency_stage1", ov1, 0);
        @(negedge clk);
        #2;
        chk("latency_out", ov1, 1);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            out_ready = (mode == 0) ? 1'b1 : 1'($urandom % 2);
        end
    end

    initial begin
        exp_t e;
        logic held1, held0;
        exp_t h1, h0;
        held1 = 0;
        held0 = 0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held1 = 0;
                held0 = 0;
                continue;
            end
            chk("in_ready1", ir1, !ov1 || out_ready);
            chk("in_ready0", ir0, !ov0 || out_ready);
            if (held1) chk("hold1", {os1, ot1, og1}, h1);
            if (held0) chk("hold0", {os0, ot0, og0}, h0);
            if (ov1) begin
                if (q1.size() == 0) chk("spurious1", ov1, 0);
                else if (out_ready) begin
                    e = q1.pop_front();
                    chk("sub1", os1, e.sub);
                    chk("t1", ot1, e.t);
                    chk("tag1", og1, e.tag);
                end
            end
            if (ov0) begin
                if (q0.size() == 0) chk("spurious0", ov0, 0);
                else if (out_ready) begin
                    e = q0.pop_front();
                    chk("sub0", os0, e.sub);
                    chk("t0", ot0, e.t);
                    chk("tag0", og0, e.tag);
                end
            end
            held1 = ov1 && !out_ready;
            held0 = ov0 && !out_ready;
            h1 = {os1, ot1, og1};
            h0 = {os0, ot0, og0};
        end
    end

    initial begin
        int n;
        build_tables();
        repeat (3) @(negedge clk);
        #2;
        chk("rst_valid", ov1, 0);
        chk("rst_sub", os1, 0);
        chk("rst_t", ot1, 0);
        chk("rst_tag", og1, 0);
        chk("rst_valid0", ov0, 0);
        rst = 1'b0;
        @(negedge clk);
        #2;
        chk("rst_in_ready", ir1, 1);

        directed(32'h00000000, 1'b0);
        chk("fwd00_sub", os1, 32'h63636363);
        chk("fwd00_t", ot1, FWD0_T);
        chk("fwd00_tag", og1, 4'h5);
        directed(32'h53000000, 1'b0);
        chk("fwd53", os1[31:24], 8'hed);
        directed(32'hed000000, 1'b1);
        chk("inv_ed", os1[31:24], 8'h53);
        directed(32'h63000000, 1'b1);
        chk("inv_63", os1[31:24], 8'h00);
        directed(32'h00000000, 1'b1);
        chk("inv00_sub", os1[31:24], 8'h52);
        chk("inv00_t", ot1[127:96], 32'h51f4a750);
        chk("noinv_sub", os0, 32'h63636363);
        chk("noinv_t", ot0, FWD0_T);

        mode = 1;
        for (int t = 0; t < 16; t++)
            send($urandom, 1'($urandom % 2), t[3:0]);
        idle();
        for (int k = 0; k < 200; k++) begin
            if ($urandom % 4 == 0) idle();
            send($urandom, 1'($urandom % 2), 4'($urandom));
        end
        for (int b = 0; b < 256; b++) begin
            logic [7:0] b8;
            b8 = 8'(b);
            send({b8, b8 ^ 8'h55, ~b8, b8 + 8'd7}, 1'b0, b8[3:0]);
            send({b8, b8 ^ 8'h55, ~b8, b8 + 8'd7}, 1'b1, b8[7:4]);
        end
        idle();
        mode = 0;
        n = 0;
        while ((q1.size() != 0 || q0.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("drain1", q1.size(), 0);
        chk("drain0", q0.size(), 0);

        send(32'h11223344, 1'b0, 4'h1);
        send(32'h55667788, 1'b1, 4'h2);
        @(negedge clk);
        rst = 1'b1;
        in_valid = 1'b0;
        q1.delete();
        q0.delete();
        @(negedge clk);
        #2;
        chk("rstf_valid", ov1, 0);
        chk("rstf_sub", os1, 0);
        chk("rstf_t", ot1, 0);
        chk("rstf_tag", og1, 0);
        chk("rstf_valid0", ov0, 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        #2;
        chk("lost_valid", ov1, 0);
        chk("lost_valid0", ov0, 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
